// File: rtl/serial_adder.sv
// Bit-serial LSB-first ripple adder: one full-add bit per clock, with a
// three-state IDLE/SHIFT/DONE controller and registered sum, carry-out and signed overflow.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Full-add cell, returned as {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    logic s;
    logic co;
    s  = x ^ y ^ c;
    co = (x & y) | (c & (x ^ y));
    return {co, s};
  endfunction

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] psum;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       fa;
  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] psum_next;

  always_comb begin
    fa        = full_add(a_sr[0], b_sr[0], carry);
    bit_s     = fa[0];
    bit_c     = fa[1];
    psum_next = {bit_s, psum[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      psum  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SHIFT;
            ready <= 1'b0;
            busy  <= 1'b1;
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            psum  <= '0;
          end
        end
        SHIFT: begin
          psum  <= psum_next;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= bit_c;
          cnt   <= cnt + 1'b1;
          // On the MSB, carry still holds the carry into bit WIDTH-1.
          if (cnt == LAST_BIT) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            sum   <= psum_next;
            cout  <= bit_c;
            ovf   <= carry ^ bit_c;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): directed corner sums, ignored start,
// mid-operation reset and 1000 back-to-back random operations with start held high.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {sum, cout, ovf}
  logic [W+1:0] sb_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] full;
    logic       v;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {full[W-1:0], full[W], v};
  endfunction

  // Presents operands with start for one cycle; returns at the negedge after the accept edge.
  task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1;
    sb_q.push_back(model(ta, tb, tc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready, busy, done} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rdy/bsy/dn=%b want 100", {ready, busy, done});
    end
    n_checks++;
    if ({sum, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got sum=%h cout=%b ovf=%b want 00 0 0", sum, cout, ovf);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    logic [W-1:0] va[5] = '{8'h00, 8'hFF, 8'h7F, 8'hFF, 8'h80};
    logic [W-1:0] vb[5] = '{8'h00, 8'h01, 8'h01, 8'hFF, 8'h80};
    logic         vc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [W+1:0] prev;
    logic [W+1:0] exp;
    int n;
    prev = '0;
    for (int i = 0; i < 5; i++) begin
      drive_start(va[i], vb[i], vc[i]);
      n_checks++;
      if ({sum, cout, ovf} !== prev || ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_hold[%0d]: got out=%h rdy=%b bsy=%b want out=%h rdy=0 bsy=1",
                 i, {sum, cout, ovf}, ready, busy, prev);
      end
      wait_done(n);
      n_checks++;
      if (n !== 8) begin
        n_fail++;
        $display("FAIL basic_latency[%0d]: got %0d cycles want 8", i, n);
      end
      exp = sb_q.pop_front();
      n_checks++;
      if ({sum, cout, ovf} !== exp || {ready, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL basic_result[%0d]: got sum=%h cout=%b ovf=%b rdy=%b bsy=%b want sum=%h cout=%b ovf=%b rdy=0 bsy=0",
                 i, sum, cout, ovf, ready, busy, exp[W+1:2], exp[1], exp[0]);
      end
      @(negedge clk);
      n_checks++;
      if ({ready, busy, done} !== 3'b100 || {sum, cout, ovf} !== exp) begin
        n_fail++;
        $display("FAIL basic_after[%0d]: got rdy/bsy/dn=%b out=%h want 100 out=%h",
                 i, {ready, busy, done}, {sum, cout, ovf}, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_start_ignored;
    logic [W+1:0] exp;
    int pulses;
    int at;
    bit rdy_bad;
    drive_start(8'h12, 8'h34, 1'b1);
    pulses = 0; at = -1; rdy_bad = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == 4) begin
        a = 8'hC3; b = 8'h99; cin = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) begin
        pulses++;
        at = n;
        exp = sb_q.pop_front();
        n_checks++;
        if ({sum, cout, ovf} !== exp) begin
          n_fail++;
          $display("FAIL ignore_result: got %h want %h", {sum, cout, ovf}, exp);
        end
      end
      if (n < 9 && ready) rdy_bad = 1;
    end
    n_checks++;
    if (pulses !== 1 || at !== 8 || rdy_bad) begin
      n_fail++;
      $display("FAIL ignore_ctrl: got pulses=%0d at=%0d ready_early=%0d want 1 8 0", pulses, at, rdy_bad);
    end
  endtask

  task automatic test_reset_mid;
    logic [W+1:0] exp;
    int pulses;
    int n;
    drive_start(8'hAA, 8'h55, 1'b1);
    void'(sb_q.pop_back());
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ready, busy, done} !== 3'b100 || {sum, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL midrst_async: got rdy/bsy/dn=%b out=%h want 100 out=000",
               {ready, busy, done}, {sum, cout, ovf});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) pulses++;
    end
    n_checks++;
    if (pulses !== 0 || {sum, cout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL midrst_nodone: got pulses=%0d out=%h want 0 out=000", pulses, {sum, cout, ovf});
    end
    drive_start(8'h3C, 8'h4B, 1'b0);
    wait_done(n);
    exp = sb_q.pop_front();
    n_checks++;
    if (n !== 8 || {sum, cout, ovf} !== exp) begin
      n_fail++;
      $display("FAIL midrst_next: got cycles=%0d out=%h want 8 out=%h", n, {sum, cout, ovf}, exp);
    end
  endtask

  task automatic test_back_to_back;
    logic [W+1:0] exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    int issued;
    int checked;
    int cyc;
    int last_done;
    issued = 0; checked = 0; cyc = 0; last_done = -1;
    @(negedge clk);
    start = 1'b1;
    while (checked < 1000 && cyc < 15000) begin
      if (ready && issued < 1000) begin
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        a = ra; b = rb; cin = rc;
        sb_q.push_back(model(ra, rb, rc));
        issued++;
      end else if (ready) begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
      if (done) begin
        if (sb_q.size() == 0) exp = 'x;
        else exp = sb_q.pop_front();
        n_checks++;
        if ({sum, cout, ovf} !== exp) begin
          n_fail++;
          $display("FAIL b2b_result[%0d]: got %h want %h", checked, {sum, cout, ovf}, exp);
        end
        if (last_done >= 0) begin
          n_checks++;
          if (cyc - last_done !== 10) begin
            n_fail++;
            $display("FAIL b2b_spacing[%0d]: got %0d want 10", checked, cyc - last_done);
          end
        end
        last_done = cyc;
        checked++;
      end
    end
    start = 1'b0;
    n_checks++;
    if (checked !== 1000) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d completions want 1000", checked);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
